// File: rtl/freq_pkg.sv
// Shared constants, FSM state type and band classifier for freq_classifier.
// The optional stability filter in freq_classifier is enabled by FREQ_STABLE_FILTER_EN.
package freq_pkg;

    localparam logic [3:0]  FREQ_NONE  = 4'd0;
    localparam logic [3:0]  FREQ_MIN   = 4'd7;
    localparam logic [3:0]  FREQ_MAX   = 4'd14;

    localparam logic [15:0] BAND_LO    = 16'd65;
    localparam logic [15:0] BAND_HI    = 16'd144;
    localparam logic [15:0] BAND_STEP  = 16'd10;
    localparam logic [15:0] BAND_ROUND = BAND_STEP >> 1;
    localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

    typedef enum logic {
        COUNT = 1'b0,
        EVAL  = 1'b1
    } gate_state_e;

    // Rounds the window edge count to the nearest 100 Hz band; anything
    // outside 650..1449 Hz (including a saturated count) reads as no tone.
    function automatic logic [3:0] classify(input logic [15:0] count);
        logic [15:0] rounded;
        logic [3:0]  band;
        rounded = count + BAND_ROUND;
        band    = 4'(rounded / BAND_STEP);
        if (count < BAND_LO || count > BAND_HI) begin
            return FREQ_NONE;
        end
        if (band < FREQ_MIN || band > FREQ_MAX) begin
            return FREQ_NONE;
        end
        return band;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge strobe.
// Shared with the bump-sensor inputs, so it carries no frequency-specific logic.
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic sync0_q;
    logic sync1_q;
    logic prev_q;
    logic rise_q;

    // Metastability chain: only sync1_q is safe to use in logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= async_i;
            sync1_q <= sync0_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= sync1_q;
            rise_q <= sync1_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/freq_classifier.sv
// Gated edge counter that turns the comparator square wave into the FreqState band code.
// Define FREQ_STABLE_FILTER_EN to require STABLE_WINDOWS matching windows before FreqState moves.
module freq_classifier
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES    = 10_000_000,
    parameter int STABLE_WINDOWS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sig_in,
    output logic [3:0]  FreqState,
    output logic        window_done,
    output logic [15:0] edge_count,
    output logic        locked
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              edgeStrobe;
    logic              captureNow;
    logic [GATE_W-1:0] gateCnt_q;
    logic [GATE_W-1:0] gateCnt_d;
    logic [15:0]       acc_q;
    logic [15:0]       acc_d;
    logic [15:0]       sample_q;
    logic [15:0]       sample_d;
    logic [15:0]       closingCount;
    logic [3:0]        windowClass;
    logic [3:0]        freq_q;
    logic [3:0]        freq_d;
    logic              lock_d;
    logic              done_q;
    logic [15:0]       count_q;
    logic              locked_q;
    gate_state_e       state_q;

    edge_sync u_edge_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (sig_in),
        .rise_o  (edgeStrobe)
    );

    // An edge landing on the capture cycle is folded into the closing window.
    always_comb begin
        captureNow   = (gateCnt_q == GATE_LAST);
        gateCnt_d    = captureNow ? '0 : gateCnt_q + GATE_W'(1);
        closingCount = (edgeStrobe && (acc_q != COUNT_MAX)) ? acc_q + 16'd1 : acc_q;
        acc_d        = captureNow ? 16'd0 : closingCount;
        sample_d     = captureNow ? closingCount : sample_q;
        windowClass  = classify(sample_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gateCnt_q <= '0;
            acc_q     <= 16'd0;
            sample_q  <= 16'd0;
        end else begin
            gateCnt_q <= gateCnt_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
        end
    end

`ifdef FREQ_STABLE_FILTER_EN
    localparam int RUN_W = (STABLE_WINDOWS > 0) ? $clog2(STABLE_WINDOWS + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STABLE_WINDOWS);

    logic [3:0]       cand_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // The run counter saturates at the limit so a long steady tone stays locked.
    always_comb begin
        run_d = run_q;
        if (windowClass == cand_q) begin
            if (run_q < RUN_LIMIT) begin
                run_d = run_q + RUN_W'(1);
            end
        end else begin
            run_d = RUN_W'(1);
        end
        freq_d = (run_d >= RUN_LIMIT) ? windowClass : freq_q;
        lock_d = (freq_d != FREQ_NONE) && (run_d >= RUN_LIMIT);
    end
`else
    logic unusedStable;
    assign unusedStable = (STABLE_WINDOWS > 0);

    always_comb begin
        freq_d = windowClass;
        lock_d = (windowClass != FREQ_NONE);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= COUNT;
            freq_q   <= FREQ_NONE;
            done_q   <= 1'b0;
            count_q  <= 16'd0;
            locked_q <= 1'b0;
`ifdef FREQ_STABLE_FILTER_EN
            cand_q   <= FREQ_NONE;
            run_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                COUNT: begin
                    if (captureNow) begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    state_q  <= COUNT;
                    count_q  <= sample_q;
                    freq_q   <= freq_d;
                    locked_q <= lock_d;
                    done_q   <= 1'b1;
`ifdef FREQ_STABLE_FILTER_EN
                    cand_q   <= windowClass;
                    run_q    <= run_d;
`endif
                end
                default: begin
                    state_q <= COUNT;
                end
            endcase
        end
    end

    assign FreqState   = freq_q;
    assign window_done = done_q;
    assign edge_count  = count_q;
    assign locked      = locked_q;

    // Invariants the display and move controller rely on.
    assert property (@(posedge clock) disable iff (reset) window_done |=> !window_done);
    assert property (@(posedge clock) disable iff (reset) locked |-> (FreqState != FREQ_NONE));
    assert property (@(posedge clock) disable iff (reset)
        (FreqState == FREQ_NONE) || ((FreqState >= FREQ_MIN) && (FreqState <= FREQ_MAX)));
    assert property (@(posedge clock) disable iff (reset) (state_q == EVAL) |=> (state_q == COUNT));

endmodule

// File: tb/tb_freq_classifier.sv
// Directed bench for freq_classifier with a short gate window and exact per-window edge counts.
// Build with FREQ_STABLE_FILTER_EN defined to exercise the stability filter sequence instead.
module tb_freq_classifier;

    localparam int GATE = 2000;
`ifdef FREQ_STABLE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sigIn = 1'b0;
    logic [3:0]  freqState;
    logic        windowDone;
    logic [15:0] edgeCount;
    logic        lockedOut;

    int errors = 0;
    int checks = 0;

    freq_classifier #(
        .GATE_CYCLES    (GATE),
        .STABLE_WINDOWS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sigIn),
        .FreqState   (freqState),
        .window_done (windowDone),
        .edge_count  (edgeCount),
        .locked      (lockedOut)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Holds reset for three clocks, checks reset values, then releases it so the
    // next posedge is local cycle 0 of the first window.
    task automatic startRun();
        @(negedge clock);
        reset = 1'b1;
        sigIn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_freq", freqState, 0);
        checkOutput("rst_done", windowDone, 0);
        checkOutput("rst_count", edgeCount, 0);
        checkOutput("rst_lock", lockedOut, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Drives local cycles 1..lastJ of a window. Rises start at cycle 4, every 4 clocks;
    // a rise at cycle j is counted at cycle j+3, so capEdge lands on the capture cycle.
    task automatic applyStimulus(input int edges, input bit capEdge, input logic level, input int lastJ);
        bit   doneSeen;
        logic s;
        doneSeen = 1'b0;
        for (int j = 1; j <= lastJ; j++) begin
            @(negedge clock);
            s = level;
            if (j >= 4 && j < 4 + 4 * edges) begin
                s = (((j - 4) % 4) < 2);
            end
            if (capEdge && (j == GATE - 4 || j == GATE - 3)) begin
                s = 1'b1;
            end
            sigIn = s;
            @(posedge clock);
            #1;
            if (windowDone) begin
                doneSeen = 1'b1;
            end
        end
        checkOutput("wdone_quiet", doneSeen, 0);
    endtask

    // Local cycle 0 of the following window: results of the closed window appear here.
    task automatic checkWindow(input string name, input int expCount, input int expFreq, input bit expLock);
        @(negedge clock);
        @(posedge clock);
        #1;
        checkOutput({name, "_done"}, windowDone, 1);
        checkOutput({name, "_count"}, edgeCount, expCount);
        checkOutput({name, "_freq"}, freqState, expFreq);
        checkOutput({name, "_lock"}, lockedOut, expLock);
    endtask

    initial begin
        int sweepEdges[6] = '{64, 65, 74, 75, 144, 145};
        int sweepFreq[6]  = '{0, 7, 7, 8, 14, 0};
        int filtEdges[5]  = '{120, 120, 90, 90, 90};
        int filtFreq[5]   = '{0, 0, 0, 0, 9};

        startRun();

`ifndef FREQ_STABLE_FILTER_EN
        applyStimulus(70, 1'b0, 1'b0, GATE - 1);
        checkWindow("e70", 70, 7, 1'b1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(sweepEdges[i], 1'b0, 1'b0, GATE - 1);
            checkWindow($sformatf("sweep%0d", sweepEdges[i]), sweepEdges[i], sweepFreq[i], sweepFreq[i] != 0);
        end

        applyStimulus(99, 1'b1, 1'b0, GATE - 1);
        checkWindow("cap", 100, 10, 1'b1);
        applyStimulus(80, 1'b0, 1'b0, GATE - 1);
        checkWindow("after_cap", 80, 8, 1'b1);
`else
        for (int i = 0; i < 5; i++) begin
            applyStimulus(filtEdges[i], 1'b0, 1'b0, GATE - 1);
            checkWindow($sformatf("filt%0d", i + 1), filtEdges[i], filtFreq[i], filtFreq[i] != 0);
        end
`endif

        applyStimulus(50, 1'b0, 1'b0, 250);
        startRun();
        applyStimulus(80, 1'b0, 1'b0, GATE - 1);
        checkWindow("post_rst", 80, FILT ? 0 : 8, !FILT);

        applyStimulus(0, 1'b0, 1'b0, GATE - 1);
        checkWindow("quiet_lo", 0, 0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, GATE - 1);
        checkWindow("step_hi", 1, 0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, GATE - 1);
        checkWindow("hold_hi", 0, 0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, GATE - 1);
        checkWindow("fall_lo", 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
